s_mem_arbiter: RTL and testbench

- Round-robin arbiter sharing the single-port S-array RAM (T words of W bits) between NREQ requesters: S-array initialiser, key-mixing engine, cipher round engine.
- Grants one owner at a time and muxes the owner's address, write data and write enable onto the RAM port.
- Routes synchronous-read data back with a per-requester valid.
- Sits between the requesters and the S RAM; requesters issue accesses only while granted.

---
 rtl/s_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_s_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_mem_arbiter.sv
// s_mem_arbiter: round-robin owner arbitration of the single-port S-array RAM among NREQ requesters.
// Optional macro S_ARB_BURST_LIMIT_EN compiles in MAX_BURST preemption while another requester waits.
module s_mem_arbiter #(
  parameter int NREQ = 3,
  parameter int T    = 16,
  parameter int W    = 32
`ifdef S_ARB_BURST_LIMIT_EN
  ,
  parameter int MAX_BURST = 8
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           iReq,
  input  logic [NREQ-1:0]           iWe,
  input  logic [NREQ*$clog2(T)-1:0] iAddr,
  input  logic [NREQ*W-1:0]         iWdata,
  output logic [NREQ-1:0]           oGnt,
  output logic [NREQ-1:0]           oRvalid,
  output logic [W-1:0]              oRdata,
  output logic [$clog2(T)-1:0]      oMem_address,
  output logic [W-1:0]              oMem_wdata,
  output logic                      oMem_we,
  input  logic [W-1:0]              iMem_rdata
);

  localparam int T_LENGTH = $clog2(T);
  localparam int PW       = $clog2(NREQ);
`ifdef S_ARB_BURST_LIMIT_EN
  localparam int BW       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
`endif

  typedef enum logic [1:0] {IDLE, GRANT, HANDOVER} state_t;

  state_t                state;
  logic [PW-1:0]         owner;
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         sel_idx;
  logic                  sel_found;
  logic [NREQ-1:0]       req_q;
  logic                  access;
  logic                  leave;
  logic [PW-1:0]         next_ptr;
`ifdef S_ARB_BURST_LIMIT_EN
  logic [BW-1:0]         burst_cnt;
`endif

  logic [T_LENGTH-1:0]   addr_arr  [NREQ];
  logic [W-1:0]          wdata_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g]  = iAddr[g*T_LENGTH +: T_LENGTH];
    assign wdata_arr[g] = iWdata[g*W +: W];
  end

  // Arbitration works on the registered request vector, which gives the two-edge grant latency.
  always_comb begin
    logic [PW:0] pos;
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    sel_idx   = '0;
    sel_found = 1'b0;
    pos       = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      pos = {1'b0, rr_ptr} + (PW+1)'(i);
      if (pos >= (PW+1)'(NREQ)) pos = pos - (PW+1)'(NREQ);
      if (req_q[pos[PW-1:0]]) begin
        sel_idx   = pos[PW-1:0];
        sel_found = 1'b1;
      end
    end
  end

  assign access   = (state == GRANT) && iReq[owner] && oGnt[owner];
  assign next_ptr = (owner == PW'(NREQ-1)) ? '0 : owner + 1'b1;

`ifdef S_ARB_BURST_LIMIT_EN
  assign leave = !iReq[owner] ||
                 (access && (burst_cnt == BW'(MAX_BURST-1)) && (|(iReq & ~oGnt)));
`else
  assign leave = !iReq[owner];
`endif

  always_comb begin
    oMem_address = '0;
    oMem_wdata   = '0;
    oMem_we      = 1'b0;
    if (access) begin
      oMem_address = addr_arr[owner];
      oMem_wdata   = wdata_arr[owner];
      oMem_we      = iWe[owner];
    end
  end

  assign oRdata = iMem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      req_q     <= '0;
      oGnt      <= '0;
      oRvalid   <= '0;
`ifdef S_ARB_BURST_LIMIT_EN
      burst_cnt <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
      req_q   <= iReq;
      oRvalid <= (access && !iWe[owner]) ? (NREQ'(1) << owner) : '0;
      case (state)
        IDLE, HANDOVER: begin
          if (sel_found) begin
            state <= GRANT;
            owner <= sel_idx;
            oGnt  <= NREQ'(1) << sel_idx;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
`ifdef S_ARB_BURST_LIMIT_EN
          // Saturates so a lone owner is preempted on its next access once someone else arrives.
          if (access && (burst_cnt != BW'(MAX_BURST-1))) burst_cnt <= burst_cnt + 1'b1;
`endif
          if (leave) begin
            state  <= HANDOVER;
            oGnt   <= '0;
            rr_ptr <= next_ptr;
`ifdef S_ARB_BURST_LIMIT_EN
            burst_cnt <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_s_mem_arbiter.sv
// tb_s_mem_arbiter: directed and randomized bench for s_mem_arbiter against a cycle-level reference model.
// Honours S_ARB_BURST_LIMIT_EN the same way as the design.
module tb_s_mem_arbiter;

  localparam int N  = 3;
  localparam int T  = 16;
  localparam int W  = 32;
  localparam int TL = $clog2(T);
`ifdef S_ARB_BURST_LIMIT_EN
  localparam int MB = 8;
  localparam int EXP_R0_CYCLES = MB;
`else
  localparam int EXP_R0_CYCLES = 17;
`endif

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    we;
  logic [N*TL-1:0] addr;
  logic [N*W-1:0]  wdata;
  logic [N-1:0]    oGnt;
  logic [N-1:0]    oRvalid;
  logic [W-1:0]    oRdata;
  logic [TL-1:0]   oMem_address;
  logic [W-1:0]    oMem_wdata;
  logic            oMem_we;
  bit   [W-1:0]    ram_rdata;
  bit   [W-1:0]    ram [T];

  s_mem_arbiter #(
    .NREQ(N), .T(T), .W(W)
`ifdef S_ARB_BURST_LIMIT_EN
    , .MAX_BURST(MB)
`endif
  ) dut (
    .clk(clk), .rst(rst), .iReq(req), .iWe(we), .iAddr(addr), .iWdata(wdata),
    .oGnt(oGnt), .oRvalid(oRvalid), .oRdata(oRdata), .oMem_address(oMem_address),
    .oMem_wdata(oMem_wdata), .oMem_we(oMem_we), .iMem_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read single-port RAM driven by the arbiter.
  always @(posedge clk) begin
    if (oMem_we) ram[oMem_address] <= oMem_wdata;
    ram_rdata <= ram[oMem_address];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int           m_owner = -1;
  int           m_ptr   = 0;
  int           m_cnt   = 0;
  int           m_rv    = -1;
  bit [W-1:0]   m_rv_data;
  bit [N-1:0]   m_prev_req;
  bit [W-1:0]   m_mem [T];
  int           acc_cnt [N];

  logic [N-1:0]  exp_gnt, exp_rvalid;
  logic          exp_access, exp_we;
  logic [TL-1:0] exp_addr;
  logic [W-1:0]  exp_wdata;

  function automatic logic [TL-1:0] addr_of(input int k);
    return addr[k*TL +: TL];
  endfunction

  function automatic logic [W-1:0] wdata_of(input int k);
    return wdata[k*W +: W];
  endfunction

  function automatic int pick(input bit [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  function automatic bit burst_preempt();
`ifdef S_ARB_BURST_LIMIT_EN
    return exp_access && (m_cnt >= MB-1) && ((req & ~exp_gnt) != '0);
`else
    return 1'b0;
`endif
  endfunction

  always_comb begin
    exp_gnt    = '0;
    exp_rvalid = '0;
    exp_access = 1'b0;
    exp_we     = 1'b0;
    exp_addr   = '0;
    exp_wdata  = '0;
    if (m_owner >= 0) begin
      exp_gnt = N'(1) << m_owner;
      if (req[m_owner]) begin
        exp_access = 1'b1;
        exp_we     = we[m_owner];
        exp_addr   = addr_of(m_owner);
        exp_wdata  = wdata_of(m_owner);
      end
    end
    if (m_rv >= 0) exp_rvalid = N'(1) << m_rv;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner    <= -1;
      m_ptr      <= 0;
      m_cnt      <= 0;
      m_rv       <= -1;
      m_prev_req <= '0;
    end else begin
      m_rv <= -1;
      if (exp_access) begin
        acc_cnt[m_owner] <= acc_cnt[m_owner] + 1;
        m_cnt            <= m_cnt + 1;
        if (we[m_owner]) m_mem[addr_of(m_owner)] <= wdata_of(m_owner);
        else begin
          m_rv      <= m_owner;
          m_rv_data <= m_mem[addr_of(m_owner)];
        end
      end
      if (m_owner >= 0) begin
        if (!req[m_owner] || burst_preempt()) begin
          m_owner <= -1;
          m_ptr   <= (m_owner + 1) % N;
          m_cnt   <= 0;
        end
      end else begin
        m_owner <= pick(m_prev_req, m_ptr);
      end
      m_prev_req <= req;
    end
  end

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      check("gnt", oGnt, exp_gnt);
      check("rvalid", oRvalid, exp_rvalid);
      check("mem_we", oMem_we, exp_we);
      check("mem_addr", oMem_address, exp_addr);
      check("mem_wdata", oMem_wdata, exp_wdata);
      if (exp_rvalid != '0) check("rdata", oRdata, m_rv_data);
    end
  endtask

  // ---------------- stimulus ----------------
  int target [N];
  bit rand_en   = 1'b0;
  int raise_pct = 0;

  // Requesters hold iReq until their target access count is reached, then drop it.
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (req[k] && acc_cnt[k] >= target[k]) req[k] = 1'b0;
      else if (!req[k] && raise_pct > 0 && $urandom_range(99) < raise_pct) begin
        req[k]    = 1'b1;
        target[k] = acc_cnt[k] + int'($urandom_range(12, 1));
      end
      if (rand_en) begin
        we[k]            = 1'($urandom_range(1));
        addr[k*TL +: TL] = TL'($urandom_range(T-1));
        wdata[k*W +: W]  = $urandom;
      end
    end
  endtask

  task automatic do_reset();
    step();
    rst = 1'b0;
    req = '0;
    step();
    step();
    rst = 1'b1;
  endtask

  logic [N-1:0] rr_gnt [13] = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b010,
                                3'b000, 3'b100, 3'b100, 3'b100, 3'b000, 3'b001};

  initial begin
    int  n0;
    bit  seen;
    rst = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    fork compare_loop(); join_none

    // Reset with all requesting, then round-robin with two accesses per tenure.
    req = '1;
    for (int k = 0; k < N; k++) target[k] = acc_cnt[k] + 2;
    repeat (3) step();
    @(negedge clk);
    check("reset_gnt", oGnt, 3'b000);
    check("reset_rvalid", oRvalid, 3'b000);
    check("reset_we", oMem_we, 1'b0);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("gnt_one_edge", oGnt, 3'b000);
    step();
    @(negedge clk);
    check("gnt_two_edges", oGnt, rr_gnt[0]);
    for (int i = 1; i < 13; i++) begin
      step();
      if (i == 4) begin
        req[0]    = 1'b1;
        target[0] = acc_cnt[0] + 2;
      end
      @(negedge clk);
      check("rr_gnt", oGnt, rr_gnt[i]);
      if (i == 2) check("last_read_rvalid", oRvalid, 3'b001);
      if (i == 3) check("handover_we", oMem_we, 1'b0);
    end
    repeat (6) step();

    // Requester 1 writes then reads address 0.
    do_reset();
    req[1] = 1'b1; target[1] = acc_cnt[1] + 2;
    we[1] = 1'b1; addr[TL +: TL] = '0; wdata[W +: W] = 32'hB7E15163;
    step();
    step();
    @(negedge clk);
    check("wr_gnt", oGnt, 3'b010);
    check("wr_we", oMem_we, 1'b1);
    check("wr_wdata", oMem_wdata, 32'hB7E15163);
    step();
    we[1] = 1'b0;
    @(negedge clk);
    check("rd_we", oMem_we, 1'b0);
    step();
    @(negedge clk);
    check("rd_rvalid", oRvalid, 3'b010);
    check("rd_rdata", oRdata, 32'hB7E15163);
    repeat (4) step();

    // Reset lands during a read access: no valid, grant drops at once.
    do_reset();
    req[1] = 1'b1; target[1] = acc_cnt[1] + 2; we[1] = 1'b0; addr[TL +: TL] = 4'd5;
    step();
    step();
    @(negedge clk);
    check("pre_reset_addr", oMem_address, 4'd5);
    #1 rst = 1'b0;
    #1;
    check("async_gnt", oGnt, 3'b000);
    check("async_addr", oMem_address, 4'd0);
    req = '0;
    step();
    @(negedge clk);
    check("reset_read_dropped", oRvalid, 3'b000);
    step();
    rst = 1'b1;

    // Requester 0 streams 16 reads while requester 2 waits.
    do_reset();
    we = '0;
    req = 3'b101; target[0] = acc_cnt[0] + 16; target[2] = acc_cnt[2] + 2;
    n0 = 0; seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      @(negedge clk);
      if (oGnt == 3'b100) seen = 1'b1;
      else if (oGnt == 3'b001) n0++;
    end
    check("burst_r2_granted", 64'(seen), 64'd1);
    check("burst_r0_cycles", 64'(n0), 64'(EXP_R0_CYCLES));
    for (int i = 0; i < 60 && req != '0; i++) step();
    check("burst_drained", req, 3'b000);
    repeat (3) step();

    // Randomized traffic with one reset in the middle.
    rand_en = 1'b1;
    raise_pct = 15;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (i == 1500) rst = 1'b0;
      if (i == 1503) rst = 1'b1;
    end
    raise_pct = 0;
    for (int i = 0; i < 300 && req != '0; i++) step();
    check("random_drained", req, 3'b000);
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
